button_repeat_arbiter: RTL and testbench
========================================

Name: button_repeat_arbiter

Overview:
- Front-end controller for the clock-setting buttons of the VGA clock.
- Generates the shared debounce sampling strobe from regular_clk and filters all raw button inputs.
- Arbitrates the buttons so exactly one owns the set-time path at a time.
- Sequences single-press and auto-repeat increment pulses for the time-keeping registers downstream.

Parameters:
- NUM_BTN, 3, number of button inputs (hour, minute, second-clear).
- TICK_DIV, 157500, regular_clk cycles per sampling tick (5 ms at 31.5 MHz); must be >= 2.
- SAMPLES, 4, consecutive equal samples needed to change a debounced level; must be >= 2.
- REPEAT_DELAY, 100, ticks a button is held before auto-repeat starts (500 ms); must be >= 1.
- REPEAT_PERIOD, 20, ticks between auto-repeat pulses (100 ms); must be >= 1.

Ports:
- regular_clk  input  1  system clock, 31.5 MHz.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  raw, asynchronous button levels, active-high.
- tick_o  output  1  one-cycle sampling strobe, exported for other slow logic.
- btn_level  output  NUM_BTN  debounced button levels.
- btn_pulse  output  NUM_BTN  one-cycle increment pulses; at most one bit set per cycle.
- busy  output  1  a button currently owns the arbiter.
- owner  output  $clog2(NUM_BTN)  index of the owning button; valid while busy.

Behaviour:
- Reset is asynchronous, active-high, on clock regular_clk. Reset clears every register: all outputs 0, prescaler 0, sample histories 0, FSM in IDLE. Reset asserted mid-sequence aborts it, and no pulse is emitted on release of reset.
- Synchroniser: each btn_raw bit passes through a 2-flop synchroniser before any use.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick_o is registered and high for exactly one cycle when the counter equals TICK_DIV-1, i.e. once every TICK_DIV cycles.
  - First tick_o occurs at cycle TICK_DIV after reset release.
- Filter, per button:
  - On each tick, shift the synchronised sample into a SAMPLES-bit history.
  - btn_level goes 1 when the history is all ones and 0 when it is all zeros; otherwise it holds.
  - btn_level updates the cycle after the history reaches its all-ones or all-zeros value.
- Rising-edge detection: rise[i] = btn_level[i] & ~prev_level[i], where prev_level is registered.
- FSM states IDLE, DELAY, REPEAT, with a tick counter rcnt sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- IDLE:
  - If any rise bit is set, grant the lowest set index: owner<=i, busy<=1, btn_pulse[i]<=1 for 1 cycle, rcnt<=0, go to DELAY.
  - A held level without a rise never grants. A button still held when another releases is ignored until it is released and pressed again.
- DELAY:
  - If btn_level[owner]==0, go to IDLE, busy<=0, no pulse.
  - Else on tick: if rcnt==REPEAT_DELAY-1, pulse btn_pulse[owner], rcnt<=0, go to REPEAT; otherwise rcnt++.
- REPEAT:
  - Release behaves as in DELAY.
  - Else on tick: if rcnt==REPEAT_PERIOD-1, pulse and set rcnt<=0; otherwise rcnt++. Continues indefinitely while held.
- Simultaneous events:
  - Release in the same cycle a pulse would fire: release wins, no pulse.
  - Rises on several buttons in the same cycle: lowest index wins; the others are never granted for that press.
  - Non-owner edges while busy are discarded.
- Latency: btn_pulse is asserted exactly 1 cycle after btn_level rises for a granted press.
- Timing: the first repeat pulse follows the first press pulse after REPEAT_DELAY ticks, counted from the first tick after the grant.
- btn_pulse is registered and one-hot or zero.

Decomposition:
- Shared package clock_ui_pkg:
  - FSM state enum (IDLE, DELAY, REPEAT).
  - Default timing constants CLK_HZ=31500000, TICK_DIV_5MS=157500, REPEAT_DELAY_TICKS=100, REPEAT_PERIOD_TICKS=20.
- Sub-module btn_sample_filter: one instance per button, containing the synchroniser, history shift register and level register. It is driven by the shared tick_o.
- Prescaler, edge detect and arbiter FSM stay in the top module.

Test Plan (TICK_DIV=4, SAMPLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2):
- Reset release, no input -> tick_o high at cycles 4, 8, 12…; all other outputs 0 throughout.
- btn_raw[1]=1 for 1 tick period, then 0 (glitch) -> btn_level stays 0, no btn_pulse.
- btn_raw[1] held stable 40 cycles, then released -> btn_level[1] rises after 4 ticks; one btn_pulse[1] the next cycle; owner=1, busy=1; repeat pulses after 3 more ticks, then every 2 ticks; on release busy=0 and pulses stop.
- btn_raw[0] and btn_raw[2] rise in the same cycle -> only btn_pulse[0]. Release 0 while holding 2 -> no pulse for 2 until 2 is released and re-pressed.
- Release timed to coincide with a due repeat tick -> no pulse that cycle; FSM returns to IDLE.
- reset asserted in REPEAT with the button held, then deasserted -> all outputs 0 immediately. Re-grant requires 4 ticks of re-filtering followed by a fresh rise.

Source files
------------

// File: rtl/button_repeat_arbiter_pkg.sv
// clock_ui_pkg: shared FSM state type and default timing constants for the clock-setting UI.
package clock_ui_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} arb_state_e;
  localparam int CLK_HZ              = 31500000;
  localparam int TICK_DIV_5MS        = 157500;
  localparam int REPEAT_DELAY_TICKS  = 100;
  localparam int REPEAT_PERIOD_TICKS = 20;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/button_repeat_arbiter_if.sv
// button_repeat_arbiter_if: raw button inputs and debounced/arbitrated outputs of the button front end.
interface button_repeat_arbiter_if #(parameter int NUM_BTN = 3);
  localparam int OW = $clog2(NUM_BTN);
  logic [NUM_BTN-1:0] btn_raw;
  logic               tick_o;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic               busy;
  logic [OW-1:0]      owner;
  modport master (output btn_raw, input tick_o, btn_level, btn_pulse, busy, owner);
  modport slave  (input btn_raw, output tick_o, btn_level, btn_pulse, busy, owner);
endinterface

// File: rtl/button_repeat_arbiter_filter.sv
// btn_sample_filter: 2-flop synchroniser plus tick-sampled history that sets/clears a debounced level.
module btn_sample_filter #(
  parameter int SAMPLES = 4
) (
  input  logic regular_clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level
);
  logic [1:0]         sync_q, sync_d;
  logic [SAMPLES-1:0] hist_q, hist_d;
  logic               level_q, level_d;
  always_comb begin
    sync_d  = {sync_q[0], raw};
    hist_d  = tick ? {hist_q[SAMPLES-2:0], sync_q[1]} : hist_q;
    level_d = &hist_q ? 1'b1 : ~|hist_q ? 1'b0 : level_q;
  end
  always_ff @(posedge regular_clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/button_repeat_arbiter.sv
// button_repeat_arbiter: debounces the set-time buttons, grants one owner at a time
// and issues single-press plus auto-repeat increment pulses.
module button_repeat_arbiter
  import clock_ui_pkg::*;
#(
  parameter int NUM_BTN       = 3,
  parameter int TICK_DIV      = TICK_DIV_5MS,
  parameter int SAMPLES       = 4,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_TICKS,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_TICKS
) (
  input logic                    regular_clk,
  input logic                    reset,
  button_repeat_arbiter_if.slave bus
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int OW = $clog2(NUM_BTN);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  logic [DW-1:0]      div_q, div_d;
  logic               tick_q, tick_d;
  logic [NUM_BTN-1:0] level_w, prev_q, prev_d, rise;
  arb_state_e         state_q, state_d;
  logic [RW-1:0]      rcnt_q, rcnt_d;
  logic [OW-1:0]      owner_q, owner_d, grant_idx;
  logic               busy_q, busy_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               held, rcnt_last;
  always_comb begin
    tick_d = div_q == DW'(TICK_DIV - 1);
    div_d  = tick_d ? '0 : div_q + 1'b1;
  end
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_filt
    btn_sample_filter #(.SAMPLES(SAMPLES)) u_filt (
      .regular_clk(regular_clk),
      .reset      (reset),
      .tick       (tick_q),
      .raw        (bus.btn_raw[g]),
      .level      (level_w[g])
    );
  end
  assign prev_d = level_w;
  assign rise   = level_w & ~prev_q;
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    pulse_d   = '0;
    grant_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) if (rise[i]) grant_idx = OW'(i);
    held      = level_w[owner_q];
    rcnt_last = state_q == DELAY ? rcnt_q == RW'(REPEAT_DELAY - 1) : rcnt_q == RW'(REPEAT_PERIOD - 1);
    if (state_q == IDLE) begin
      if (|rise) begin
        state_d            = DELAY;
        owner_d            = grant_idx;
        busy_d             = 1'b1;
        pulse_d[grant_idx] = 1'b1;
        rcnt_d             = '0;
      end
    end else if (!held) begin
      // release outranks a repeat pulse that falls due in the same cycle
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (tick_q) begin
      if (rcnt_last) begin
        pulse_d[owner_q] = 1'b1;
        rcnt_d           = '0;
        state_d          = REPEAT;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge regular_clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      prev_q  <= '0;
      state_q <= IDLE;
      rcnt_q  <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      pulse_q <= '0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
    end
  end
  assign bus.tick_o    = tick_q;
  assign bus.btn_level = level_w;
  assign bus.btn_pulse = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_button_repeat_arbiter.sv
// tb_button_repeat_arbiter: directed and random button stimulus checked against a tick-counting reference model.
module tb_button_repeat_arbiter;
  localparam int N  = 3;
  localparam int TD = 4;
  localparam int S  = 4;
  localparam int RD = 3;
  localparam int RP = 2;
  logic regular_clk = 1'b0;
  logic reset       = 1'b1;
  int checks = 0;
  int errors = 0;
  button_repeat_arbiter_if #(.NUM_BTN(N)) b();
  button_repeat_arbiter #(
    .NUM_BTN(N), .TICK_DIV(TD), .SAMPLES(S), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .regular_clk(regular_clk),
    .reset      (reset),
    .bus        (b)
  );
  always #5 regular_clk = ~regular_clk;
  int           k;
  logic [N-1:0] raws[$];
  logic [N-1:0] samp[$];
  logic [N-1:0] lvl1, lvl2, m_pulse;
  logic         tick1, m_busy;
  int           m_owner, held;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    k = 0;
    raws.delete();
    samp.delete();
    lvl1 = '0; lvl2 = '0; m_pulse = '0;
    tick1 = 1'b0; m_busy = 1'b0; m_owner = 0; held = 0;
  endtask
  // level follows a unanimous window of the last S tick samples; ticks since grant drive the pulses
  task automatic model_edge(input logic [N-1:0] r);
    logic [N-1:0] nl;
    logic         nt, ones, zeros, v;
    int           idx, first;
    k++;
    raws.push_back(r);
    nt = (k % TD) == 0;
    nl = lvl1;
    for (int i = 0; i < N; i++) begin
      ones = 1'b1; zeros = 1'b1;
      for (int j = 0; j < S; j++) begin
        idx = samp.size() - 1 - j;
        v = idx >= 0 ? samp[idx][i] : 1'b0;
        ones &= v;
        zeros &= !v;
      end
      if (ones) nl[i] = 1'b1;
      else if (zeros) nl[i] = 1'b0;
    end
    m_pulse = '0;
    if (!m_busy) begin
      first = -1;
      for (int i = 0; i < N; i++) if (first < 0 && lvl1[i] && !lvl2[i]) first = i;
      if (first >= 0) begin
        m_busy = 1'b1; m_owner = first; m_pulse[first] = 1'b1; held = 0;
      end
    end else if (!lvl1[m_owner]) begin
      m_busy = 1'b0;
    end else if (tick1) begin
      held++;
      if (held == RD || (held > RD && (held - RD) % RP == 0)) m_pulse[m_owner] = 1'b1;
    end
    if (k > 1 && (k - 1) % TD == 0) samp.push_back(raws[k - 3]);
    lvl2 = lvl1; lvl1 = nl; tick1 = nt;
  endtask
  task automatic compare();
    check("tick_o", 32'(b.tick_o), 32'(tick1));
    check("btn_level", 32'(b.btn_level), 32'(lvl1));
    check("btn_pulse", 32'(b.btn_pulse), 32'(m_pulse));
    check("busy", 32'(b.busy), 32'(m_busy));
    if (m_busy) check("owner", 32'(b.owner), 32'(m_owner));
  endtask
  task automatic step(input logic [N-1:0] r);
    b.btn_raw = r;
    @(posedge regular_clk);
    if (reset) model_reset();
    else model_edge(r);
    @(negedge regular_clk);
    compare();
  endtask
  task automatic hold(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask
  task automatic pulse_reset(input logic [N-1:0] r, input int n);
    reset = 1'b1;
    model_reset();
    #1 compare();
    hold(r, n);
    reset = 1'b0;
  endtask
  initial begin
    logic [N-1:0] r;
    b.btn_raw = '0;
    model_reset();
    @(negedge regular_clk);
    hold('0, 3);
    reset = 1'b0;
    hold(3'b000, 30);
    hold(3'b010, TD);
    hold(3'b000, 40);
    hold(3'b010, 40);
    hold(3'b000, 40);
    hold(3'b101, 40);
    hold(3'b100, 40);
    hold(3'b000, 30);
    hold(3'b100, 40);
    hold(3'b000, 30);
    for (int d = 40; d < 50; d++) begin
      hold(3'b010, d);
      hold(3'b000, 30);
    end
    hold(3'b010, 60);
    pulse_reset(3'b010, 3);
    hold(3'b010, 60);
    hold(3'b000, 30);
    r = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 1999) == 0) pulse_reset(r, $urandom_range(1, 4));
      step(r);
    end
    hold(3'b000, 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
